rr_grant_arbiter: RTL and testbench

- Registered, work-conserving round-robin arbiter.
- Consumes a request vector and produces a held one-hot grant with a valid/ready handshake toward the downstream resource.
- Priority masking is a thermometer "strictly above last winner" mask; the winner is the lowest set bit of the masked requests, falling back to the lowest set bit of the unmasked requests.
- Sits in front of shared vector-lane and memory ports, wherever N requesters contend for one resource.

---
 rtl/rr_grant_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_grant_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
//   Registered, work-conserving round-robin arbiter. Samples a level request
//   vector, presents a held one-hot grant with a valid/ready handshake, and
//   rotates priority so the last accepted winner becomes lowest priority.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset (released synchronously)
//   request_vector per-requester request, level sensitive
//   lock           sampled on accept: re-present the same winner (burst)
//   grant_ready    downstream accepts the current grant
//   grant          one-hot grant, all zero when grant_valid is low
//   grant_index    binary index of grant
//   grant_valid    a grant is being presented
//   grant_count    number of accepted grants, wraps modulo 2^CNT_W
module rr_grant_arbiter #(
    parameter int VECTOR_IN = 8,
    parameter int IDX_W     = $clog2(VECTOR_IN),
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [VECTOR_IN-1:0] request_vector,
    input  logic                 lock,
    input  logic                 grant_ready,
    output logic [VECTOR_IN-1:0] grant,
    output logic [IDX_W-1:0]     grant_index,
    output logic                 grant_valid,
    output logic [CNT_W-1:0]     grant_count
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;          // last accepted winner
    logic [IDX_W-1:0] idle_winner;  // winner using the stored pointer
    logic [IDX_W-1:0] next_winner;  // winner using the grant being accepted
    logic             accept;

    // Lowest requester strictly above 'last', otherwise lowest requester
    // overall. Callers only use the result when req is nonzero.
    function automatic logic [IDX_W-1:0] pick_winner(
        input logic [VECTOR_IN-1:0] req,
        input logic [IDX_W-1:0]     last
    );
        logic             found_masked;
        logic             found_any;
        logic [IDX_W-1:0] masked_idx;
        logic [IDX_W-1:0] any_idx;
        found_masked = 1'b0;
        found_any    = 1'b0;
        masked_idx   = '0;
        any_idx      = '0;
        for (int i = 0; i < VECTOR_IN; i++) begin
            if (req[i] && !found_any) begin
                any_idx   = IDX_W'(i);
                found_any = 1'b1;
            end
            if (req[i] && (IDX_W'(i) > last) && !found_masked) begin
                masked_idx   = IDX_W'(i);
                found_masked = 1'b1;
            end
        end
        return found_masked ? masked_idx : any_idx;
    endfunction

    function automatic logic [VECTOR_IN-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [VECTOR_IN-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // NOTE: every signal driven here gets a value on every path (function
    // results are total), so no latch can be inferred.
    always_comb begin
        idle_winner = pick_winner(request_vector, ptr);
        // On a non-locked accept the pointer moves to grant_index in the same
        // edge, so the new mask must come from grant_index, not the old ptr.
        next_winner = pick_winner(request_vector, grant_index);
        accept      = grant_valid & grant_ready;
    end

    // NOTE: state and outputs use non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= IDX_W'(VECTOR_IN - 1);  // index 0 wins first
            grant       <= '0;
            grant_index <= '0;
            grant_valid <= 1'b0;
            grant_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|request_vector) begin
                        grant       <= to_onehot(idle_winner);
                        grant_index <= idle_winner;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Without an accept the grant is frozen; request changes
                    // are ignored and a grant is never revoked.
                    if (accept) begin
                        grant_count <= grant_count + CNT_W'(1);
                        // Locked accept: pointer and grant stay as they are.
                        if (!lock) begin
                            ptr <= grant_index;
                            if (|request_vector) begin
                                grant       <= to_onehot(next_winner);
                                grant_index <= next_winner;
                            end else begin
                                grant       <= '0;
                                grant_index <= '0;
                                grant_valid <= 1'b0;
                                state       <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter
//   Self-checking bench for rr_grant_arbiter. A behavioural model tracks the
//   presented grant, the last accepted winner and the accept count; the
//   round-robin choice is a rotating search starting just after the last
//   winner.
module tb_rr_grant_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [N-1:0]     request_vector;
    logic             lock;
    logic             grant_ready;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_index;
    logic             grant_valid;
    logic [CNT_W-1:0] grant_count;

    int tests_run;
    int tests_failed;

    // reference model state
    bit          m_valid;
    int          m_idx;
    int          m_last;
    int unsigned m_count;

    rr_grant_arbiter #(
        .VECTOR_IN(N),
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .request_vector(request_vector),
        .lock          (lock),
        .grant_ready   (grant_ready),
        .grant         (grant),
        .grant_index   (grant_index),
        .grant_valid   (grant_valid),
        .grant_count   (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Search requesters in circular order starting just after 'last'.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] v;
        v = '0;
        if (m_valid) v[m_idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] exp_index();
        return m_valid ? IDX_W'(m_idx) : '0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = N - 1;
        m_count = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic lk, input logic rdy);
        if (!m_valid) begin
            if (req != '0) begin
                m_idx   = rr_pick(req, m_last);
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            m_count++;
            if (!lk) begin
                m_last = m_idx;
                if (req != '0) m_idx = rr_pick(req, m_last);
                else m_valid = 1'b0;
            end
        end
    endtask

    // Apply inputs for one clock, advance the model on the edge and leave
    // the bench 1 time unit after the edge, where outputs are compared.
    task automatic tick(input logic [N-1:0] req, input logic lk, input logic rdy);
        request_vector = req;
        lock           = lk;
        grant_ready    = rdy;
        @(posedge clk);
        model_step(req, lk, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        request_vector = '0;
        lock           = 1'b0;
        grant_ready    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({grant_valid, grant, grant_index} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b grant=%h idx=%0d, expected all zero",
                     grant_valid, grant, grant_index);
        end
        tests_run++;
        if (grant_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d expected 0", grant_count);
        end
        // idle with no requests: still nothing presented
        tick('0, 1'b0, 1'b1);
        tests_run++;
        if (grant_valid !== 1'b0 || grant_count !== '0) begin
            tests_failed++;
            $display("FAIL idle_no_req: valid=%b count=%0d expected 0/0", grant_valid, grant_count);
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0] exp_seq [4];
        exp_seq = '{8'h01, 8'h80, 8'h01, 8'h80};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick(8'h81, 1'b0, 1'b1);
            tests_run++;
            if (grant_valid !== 1'b1 || grant !== exp_seq[c] || grant !== exp_grant()) begin
                tests_failed++;
                $display("FAIL alternate_81[%0d]: valid=%b grant=%h expected %h", c,
                         grant_valid, grant, exp_seq[c]);
            end
        end
        // three of the four presented grants were accepted so far
        tests_run++;
        if (grant_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL alternate_count: got %0d expected 3", grant_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(8'hFF, 1'b0, 1'b1);
        for (int c = 0; c <= N; c++) begin
            logic [N-1:0] want;
            want = N'(1) << (c % N);
            tests_run++;
            if (grant_valid !== 1'b1 || grant !== want || grant_index !== IDX_W'(c % N)) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: valid=%b grant=%h idx=%0d expected %h",
                         c, grant_valid, grant, grant_index, want);
            end
            tick(8'hFF, 1'b0, 1'b1);
        end
    endtask

    task automatic test_hold();
        logic [CNT_W-1:0] cnt0;
        do_reset();
        tick(8'h04, 1'b0, 1'b0);
        cnt0 = grant_count;
        for (int c = 0; c < 5; c++) begin
            tick((c % 2) ? 8'hF0 : 8'h00, 1'b0, 1'b0);
            tests_run++;
            if (grant_valid !== 1'b1 || grant !== 8'h04 || grant_index !== 3'd2 ||
                grant_count !== cnt0) begin
                tests_failed++;
                $display("FAIL hold[%0d]: valid=%b grant=%h idx=%0d count=%0d expected 1/04/2/%0d",
                         c, grant_valid, grant, grant_index, grant_count, cnt0);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        tick(8'h08, 1'b0, 1'b0);  // winner idx3, not yet accepted
        tests_run++;
        if (grant !== 8'h08) begin
            tests_failed++;
            $display("FAIL lock_setup: grant=%h expected 08", grant);
        end
        for (int c = 0; c < 3; c++) begin
            tick(8'hFF, 1'b1, 1'b1);
            tests_run++;
            if (grant_valid !== 1'b1 || grant !== 8'h08 || grant_index !== 3'd3) begin
                tests_failed++;
                $display("FAIL lock_burst[%0d]: grant=%h idx=%0d expected 08/3", c, grant, grant_index);
            end
        end
        tick(8'hFF, 1'b0, 1'b1);
        tests_run++;
        if (grant !== 8'h10 || grant_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL lock_release: grant=%h count=%0d expected 10/4", grant, grant_count);
        end
    endtask

    task automatic test_drain();
        do_reset();
        tick(8'h20, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b1);  // accept with nothing pending
        tests_run++;
        if (grant_valid !== 1'b0 || grant !== '0) begin
            tests_failed++;
            $display("FAIL drain_idle: valid=%b grant=%h expected 0/00", grant_valid, grant);
        end
        tick(8'h40, 1'b0, 1'b0);
        tests_run++;
        if (grant_valid !== 1'b1 || grant !== 8'h40 || grant_index !== 3'd6) begin
            tests_failed++;
            $display("FAIL drain_regrant: valid=%b grant=%h idx=%0d expected 1/40/6",
                     grant_valid, grant, grant_index);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        tick(8'hFF, 1'b0, 1'b1);
        tick(8'hFF, 1'b0, 1'b1);
        tick(8'hFF, 1'b0, 1'b0);  // grant pending, not accepted
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if ({grant_valid, grant, grant_index} !== '0 || grant_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b grant=%h idx=%0d count=%0d expected all zero",
                     grant_valid, grant, grant_index, grant_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(8'hFF, 1'b0, 1'b0);
        tests_run++;
        if (grant_valid !== 1'b1 || grant !== 8'h01) begin
            tests_failed++;
            $display("FAIL reset_mid_first: valid=%b grant=%h expected 1/01", grant_valid, grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] req;
            req = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            tick(req, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
            tests_run++;
            if (grant_valid !== m_valid || grant !== exp_grant() ||
                (m_valid && grant_index !== exp_index()) ||
                grant_count !== CNT_W'(m_count) || !$onehot0(grant)) begin
                tests_failed++;
                $display("FAIL random[%0d]: valid=%b grant=%h idx=%0d count=%0d expected %b/%h/%0d/%0d",
                         c, grant_valid, grant, grant_index, grant_count,
                         m_valid, exp_grant(), exp_index(), m_count);
            end
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        request_vector = '0;
        lock           = 1'b0;
        grant_ready    = 1'b0;
        model_reset();
        test_reset();
        test_alternate();
        test_back_to_back();
        test_hold();
        test_lock();
        test_drain();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
